// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch front end.
// Line entries carry the captured line plus its base address and entry word.
package fetch_pkg;

  typedef logic [127:0] line_t;
  typedef logic [31:0]  instr_t;

  typedef struct packed {
    line_t       line;
    logic [31:0] base;
    logic [1:0]  start;
  } line_entry_t;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_e;

  localparam logic [31:0] PC_UPPER_ADDR = 32'h3FF;

endpackage

// File: rtl/line_fifo.sv
// Small synchronous FIFO of captured cache lines with flush.
// The entry behind the head is exposed so its start word is known early.
module line_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  line_entry_t   push_data,
  input  logic          pop,
  output line_t         head_line,
  output logic [31:0]   head_base,
  output logic [1:0]    next_start,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  line_entry_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  assign head_line  = mem[rd_ptr].line;
  assign head_base  = mem[rd_ptr].base;
  assign next_start = mem[rd_ptr + AW'(1)].start;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_requester.sv
// Instruction-fetch requester: issues i_cache reads, buffers lines,
// and hands decode one instruction per cycle with redirect support.
module fetch_requester
  import fetch_pkg::*;
#(
  parameter logic [31:0] PC_RESET   = 32'h0000_0000,
  parameter int          LINE_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  output logic [31:0]   pc_out,
  output logic          rd_en,
  output logic          abort,
  input  logic [127:0]  cache_dout,
  input  logic          cache_dout_valid,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic [31:0]   instr_out,
  output logic [31:0]   instr_pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic          fetch_fault
);

  localparam int CW = $clog2(LINE_DEPTH + 1);

  fetch_state_e  state_q;
  fetch_state_e  state_d;
  logic [31:0]   fetch_pc;
  logic [1:0]    slot;
  logic          fault_q;
  logic          req;

  line_t         head_line;
  logic [31:0]   head_base;
  logic [1:0]    next_start;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  logic          capture;
  logic          miss;
  logic          pop_beat;
  logic          line_pop;
  line_entry_t   push_data;

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    abort   = 1'b0;
    if (!rst) begin
      abort = redirect_valid;
      unique case (state_q)
        FETCH: begin
          req = !full && !redirect_valid;
          if (req && !cache_dout_valid) begin
            state_d = HALT;
          end
        end
        HALT: begin
          req = 1'b0;
        end
        default: begin
          req = 1'b0;
        end
      endcase
      if (redirect_valid) begin
        state_d = FETCH;
      end
    end
  end

  assign rd_en   = req;
  assign pc_out  = fetch_pc;
  assign capture = req && cache_dout_valid;
  assign miss    = req && !cache_dout_valid;

  assign pop_beat = !empty && instr_ready && !redirect_valid;
  assign line_pop = pop_beat && (slot == 2'd3);

  assign push_data = '{
    line:  cache_dout,
    base:  {fetch_pc[31:4], 4'b0000},
    start: fetch_pc[3:2]
  };

  line_fifo #(
    .DEPTH(LINE_DEPTH)
  ) u_line_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (capture),
    .push_data (push_data),
    .pop       (line_pop),
    .head_line (head_line),
    .head_base (head_base),
    .next_start(next_start),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign instr_valid = !empty;
  assign instr_out   = empty ? '0 : head_line[{slot, 5'b00000} +: 32];
  assign instr_pc    = empty ? '0 : head_base + {28'd0, slot, 2'b00};
  assign fetch_fault = fault_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= PC_RESET;
      fault_q  <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      fault_q  <= 1'b0;
    end else if (capture) begin
      fetch_pc <= {fetch_pc[31:4], 4'b0000} + 32'd16;
    end else if (miss) begin
      fault_q  <= 1'b1;
    end
  end

  // A newly pushed line becomes head when the queue is or goes empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot <= 2'd0;
    end else if (redirect_valid) begin
      slot <= 2'd0;
    end else if (pop_beat) begin
      if (slot != 2'd3) begin
        slot <= slot + 2'd1;
      end else if (count > CW'(1)) begin
        slot <= next_start;
      end else if (capture) begin
        slot <= push_data.start;
      end else begin
        slot <= 2'd0;
      end
    end else if (empty && capture) begin
      slot <= push_data.start;
    end
  end

endmodule

// File: tb/tb_fetch_requester.sv
// Directed and random checks of fetch_requester against a queue-of-addresses
// model of the fetch stream.
module tb_fetch_requester;

  localparam logic [31:0] PC_UPPER = 32'h3FF;
  localparam int          DEPTH    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   pc_out;
  logic          rd_en;
  logic          abort;
  logic [127:0]  cache_dout;
  logic          cache_dout_valid;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic [31:0]   instr_out;
  logic [31:0]   instr_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic          fetch_fault;

  int checks = 0;
  int errors = 0;
  int nreq   = 0;

  logic [31:0] iq [$];
  logic [31:0] mpc;
  bit          mhalt;
  bit          mfault;

  always #5 clk = ~clk;

  fetch_requester #(
    .PC_RESET  (32'h0000_0000),
    .LINE_DEPTH(DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_out          (pc_out),
    .rd_en           (rd_en),
    .abort           (abort),
    .cache_dout      (cache_dout),
    .cache_dout_valid(cache_dout_valid),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .instr_out       (instr_out),
    .instr_pc        (instr_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .fetch_fault     (fetch_fault)
  );

  function automatic logic [31:0] wd(input logic [31:0] a);
    logic [31:0] w;
    w = (a >> 2) * 32'h9E37_79B1;
    return w ^ 32'hC3A5_0F1E;
  endfunction

  logic [31:0] cbase;
  assign cbase            = {pc_out[31:4], 4'b0000};
  assign cache_dout       = {wd(cbase + 12), wd(cbase + 8),
                             wd(cbase + 4), wd(cbase)};
  assign cache_dout_valid = (pc_out <= PC_UPPER);

  function automatic int nlines();
    int n = 0;
    for (int i = 0; i < iq.size(); i++) begin
      if (i == 0 || iq[i][31:4] != iq[i-1][31:4]) n++;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    iq.delete();
    mpc    = 32'h0;
    mhalt  = 1'b0;
    mfault = 1'b0;
  endtask

  // Drive one cycle at the falling edge, check, then advance the model.
  task automatic step(input bit rdy, input bit rv, input logic [31:0] rpc);
    bit          exp_rd;
    logic [31:0] base;
    instr_ready    = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    exp_rd = !mhalt && (nlines() < DEPTH) && !rv;
    chk("pc_out", pc_out, mpc);
    chk("rd_en", 32'(rd_en), 32'(exp_rd));
    chk("abort", 32'(abort), 32'(rv));
    chk("instr_valid", 32'(instr_valid), 32'(iq.size() > 0));
    chk("fetch_fault", 32'(fetch_fault), 32'(mfault));
    if (iq.size() > 0) begin
      chk("instr_pc", instr_pc, iq[0]);
      chk("instr_out", instr_out, wd(iq[0]));
    end
    if (rd_en) nreq++;
    if (rv) begin
      iq.delete();
      mpc    = rpc;
      mhalt  = 1'b0;
      mfault = 1'b0;
    end else begin
      if (iq.size() > 0 && rdy) void'(iq.pop_front());
      if (exp_rd) begin
        if (mpc <= PC_UPPER) begin
          base = mpc & ~32'hF;
          for (int k = int'(mpc[3:2]); k < 4; k++) begin
            iq.push_back(base + 32'(4 * k));
          end
          mpc = base + 32'd16;
        end else begin
          mhalt  = 1'b1;
          mfault = 1'b1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pc_out"}, pc_out, 32'h0);
    chk({tag, "_rd_en"}, 32'(rd_en), 32'h0);
    chk({tag, "_abort"}, 32'(abort), 32'h0);
    chk({tag, "_valid"}, 32'(instr_valid), 32'h0);
    chk({tag, "_instr_out"}, instr_out, 32'h0);
    chk({tag, "_instr_pc"}, instr_pc, 32'h0);
    chk({tag, "_fault"}, 32'(fetch_fault), 32'h0);
  endtask

  initial begin
    rst            = 1'b1;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Sequential fetch from PC_RESET.
    for (int i = 0; i < 12; i++) step(1, 0, 0);

    // Decode stalled: exactly two lines are requested.
    step(1, 1, 32'h0);
    nreq = 0;
    for (int i = 0; i < 20; i++) step(0, 0, 0);
    chk("stall_req_count", 32'(nreq), 32'd2);
    for (int i = 0; i < 10; i++) step(1, 0, 0);

    // Redirect into mid-line while the queue is full.
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    step(0, 1, 32'h48);
    for (int i = 0; i < 6; i++) step(1, 0, 0);

    // Walk into the out-of-range line, drain, then recover.
    step(1, 1, 32'h3C0);
    for (int i = 0; i < 30; i++) step(1, 0, 0);
    chk("fault_sticky", 32'(fetch_fault), 32'h1);
    step(1, 1, 32'h0);
    chk("fault_cleared", 32'(fetch_fault), 32'h0);
    for (int i = 0; i < 4; i++) step(1, 0, 0);

    // Redirect landing on a slot-3 pop.
    step(1, 1, 32'h0C);
    step(1, 0, 0);
    step(1, 1, 32'h100);
    for (int i = 0; i < 6; i++) step(1, 0, 0);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    redirect_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) step(1, 0, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0,
           32'($urandom_range(0, 32'h41F)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
